// File: rtl/memory_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port memory with a registered read port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (port 0) otherwise.
module memory_arbiter #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 p0_req,
   input  logic                 p0_we,
   input  logic [ADDR_SIZE-1:0] p0_addr,
   input  logic [WORD_SIZE-1:0] p0_wdata,
   output logic                 p0_ack,
   output logic [WORD_SIZE-1:0] p0_rdata,
   input  logic                 p1_req,
   input  logic                 p1_we,
   input  logic [ADDR_SIZE-1:0] p1_addr,
   input  logic [WORD_SIZE-1:0] p1_wdata,
   output logic                 p1_ack,
   output logic [WORD_SIZE-1:0] p1_rdata,
   output logic                 busy,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_data_in,
   output logic                 mem_we,
   output logic                 mem_oe,
   input  logic [WORD_SIZE-1:0] mem_data_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_r, state_s;
   logic                 winner_r, winner_s;
   logic                 we_r, we_s;
   logic [ADDR_SIZE-1:0] addr_r, addr_s;
   logic [WORD_SIZE-1:0] wdata_r, wdata_s;
   logic                 mem_we_r, mem_we_s;
   logic                 mem_oe_r, mem_oe_s;
   logic                 any_req_s;
   logic                 pick_s;
   logic                 sel_we_s;
   logic [ADDR_SIZE-1:0] sel_addr_s;
   logic [WORD_SIZE-1:0] sel_wdata_s;
   logic                 done_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic                 last_grant_r, last_grant_s;
`endif

   // Arbitration: pick the winning port (0 or 1) and mux its request fields
   always_comb begin
      any_req_s = p0_req | p1_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (p0_req && p1_req) begin
         pick_s = ~last_grant_r;
      end else begin
         pick_s = p1_req;
      end
`else
      if (p0_req) begin
         pick_s = 1'b0;
      end else begin
         pick_s = p1_req;
      end
`endif
      if (pick_s) begin
         sel_we_s    = p1_we;
         sel_addr_s  = p1_addr;
         sel_wdata_s = p1_wdata;
      end else begin
         sel_we_s    = p0_we;
         sel_addr_s  = p0_addr;
         sel_wdata_s = p0_wdata;
      end
   end

   // Next-state logic; strobes are computed one cycle ahead so they leave a register in ISSUE
   always_comb begin
      state_s  = state_r;
      winner_s = winner_r;
      we_s     = we_r;
      addr_s   = addr_r;
      wdata_s  = wdata_r;
      mem_we_s = 1'b0;
      mem_oe_s = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_s = last_grant_r;
`endif
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               state_s  = ISSUE;
               winner_s = pick_s;
               we_s     = sel_we_s;
               addr_s   = sel_addr_s;
               wdata_s  = sel_wdata_s;
               mem_we_s = sel_we_s;
               mem_oe_s = ~sel_we_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               last_grant_s = pick_s;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE:   state_s = DONE;
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State and latched-request registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= IDLE;
         winner_r <= 1'b0;
         we_r     <= 1'b0;
         addr_r   <= {ADDR_SIZE{1'b0}};
         wdata_r  <= {WORD_SIZE{1'b0}};
         mem_we_r <= 1'b0;
         mem_oe_r <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_grant_r <= 1'b1;
`endif
      end else begin
         state_r  <= state_s;
         winner_r <= winner_s;
         we_r     <= we_s;
         addr_r   <= addr_s;
         wdata_r  <= wdata_s;
         mem_we_r <= mem_we_s;
         mem_oe_r <= mem_oe_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_grant_r <= last_grant_s;
`endif
      end
   end

   // Port responses; a reset in DONE suppresses the ack, and rdata is zero without an ack
   always_comb begin
      busy        = (state_r != IDLE);
      mem_addr    = addr_r;
      mem_data_in = wdata_r;
      mem_we      = mem_we_r;
      mem_oe      = mem_oe_r;
      done_s      = (state_r == DONE) & ~rst;
      p0_ack      = done_s & ~winner_r;
      p1_ack      = done_s & winner_r;
      if (p0_ack && !we_r) begin
         p0_rdata = mem_data_out;
      end else begin
         p0_rdata = {WORD_SIZE{1'b0}};
      end
      if (p1_ack && !we_r) begin
         p1_rdata = mem_data_out;
      end else begin
         p1_rdata = {WORD_SIZE{1'b0}};
      end
   end

endmodule
